// File: rtl/frame_builder.sv
// frame_builder: serialises one UDP/IPv4/Ethernet frame per tx_start onto an
// 8-bit valid/ready stream: preamble+SFD, Ethernet, IPv4 and UDP headers, then
// the payload passed straight through from the s_* stream. No FCS is appended.
// Build option: define FRAME_BUILDER_IP_CSUM_EN to generate the IPv4 header
// checksum; without it the checksum bytes go out as zero.
//
// state    | meaning
// IDLE     | tx_ready high, waiting for tx_start with a legal length
// PREAMBLE | 7 x 0x55 then 0xD5
// ETH      | destination MAC, source MAC, ethertype 0x0800
// IP       | 20-byte IPv4 header
// UDP      | 8-byte UDP header
// PAYLOAD  | s_* stream passed through to m_*, tx_len bytes
// PAD      | payload ended early, zero bytes fill up to tx_len
// DRAIN    | payload overran tx_len, input discarded up to s_tlast
module frame_builder #(
  parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC  = 48'h0200_0000_0001,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_0001,
  parameter logic [31:0] DST_IP   = 32'hC0A8_0002,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [15:0] DST_PORT = 16'd5001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [15:0] tx_len,
  output logic        tx_ready,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic        len_err
);
  localparam logic [15:0] MAX_LEN = 16'd1472;

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ETH, S_IP, S_UDP, S_PAYLOAD, S_PAD, S_DRAIN
  } state_t;

  state_t            state_q, state_d, hdr_next;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       ident_q, ident_d;
  logic              len_err_q, len_err_d;
  logic [15:0]       ip_total_len, udp_len, ip_csum;
  logic [0:13][7:0]  eth_b;
  logic [0:19][7:0]  ip_b;
  logic [0:7][7:0]   udp_b;
  logic              hdr_state;
  logic [4:0]        hdr_end;
  logic              last_byte;

  // header images indexed directly by the byte counter (element 0 goes out first)
  assign ip_total_len = len_q + 16'd28;
  assign udp_len      = len_q + 16'd8;
  assign eth_b        = {DST_MAC, SRC_MAC, 16'h0800};
  assign ip_b         = {16'h4500, ip_total_len, ident_q, 16'h4000, 8'h40, 8'h11,
                         ip_csum, SRC_IP, DST_IP};
  assign udp_b        = {SRC_PORT, DST_PORT, udp_len, 16'h0000};
  assign last_byte    = (cnt_q == len_q - 16'd1);
  assign tx_ready     = (state_q == S_IDLE);
  assign len_err      = len_err_q;

`ifdef FRAME_BUILDER_IP_CSUM_EN
  logic [19:0] csum_sum;
  logic [16:0] csum_fold;

  // ones-complement sum of the ten header words with the checksum word as zero
  always_comb begin
    csum_sum  = {4'h0, 16'h4500} + {4'h0, ip_total_len} + {4'h0, ident_q}
              + {4'h0, 16'h4000} + {4'h0, 16'h4011}
              + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
              + {4'h0, DST_IP[31:16]} + {4'h0, DST_IP[15:0]};
    csum_fold = {1'b0, csum_sum[15:0]} + {13'h0, csum_sum[19:16]};
    ip_csum   = ~(csum_fold[15:0] + {15'h0, csum_fold[16]});
  end
`else
  assign ip_csum = 16'h0000;
`endif

  // state, counters and the registered length-error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      len_q     <= 16'd0;
      ident_q   <= 16'd0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ident_q   <= ident_d;
      len_err_q <= len_err_d;
    end
  end

  // next-state, counter advance and stream outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ident_d   = ident_q;
    len_err_d = 1'b0;
    m_tvalid  = 1'b0;
    m_tdata   = 8'h00;
    m_tlast   = 1'b0;
    s_tready  = 1'b0;
    hdr_state = 1'b0;
    hdr_end   = 5'd0;
    hdr_next  = S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (tx_len != 16'd0 && tx_len <= MAX_LEN) begin
            len_d   = tx_len;
            cnt_d   = 16'd0;
            state_d = S_PREAMBLE;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        hdr_state = 1'b1;
        hdr_end   = 5'd7;
        hdr_next  = S_ETH;
        m_tdata   = (cnt_q[2:0] == 3'd7) ? 8'hD5 : 8'h55;
      end
      S_ETH: begin
        hdr_state = 1'b1;
        hdr_end   = 5'd13;
        hdr_next  = S_IP;
        m_tdata   = eth_b[cnt_q[3:0]];
      end
      S_IP: begin
        hdr_state = 1'b1;
        hdr_end   = 5'd19;
        hdr_next  = S_UDP;
        m_tdata   = ip_b[cnt_q[4:0]];
      end
      S_UDP: begin
        hdr_state = 1'b1;
        hdr_end   = 5'd7;
        hdr_next  = S_PAYLOAD;
        m_tdata   = udp_b[cnt_q[2:0]];
      end
      S_PAYLOAD: begin
        m_tvalid = s_tvalid;
        m_tdata  = s_tdata;
        m_tlast  = s_tvalid && last_byte;
        s_tready = m_tready;
        if (s_tvalid && m_tready) begin
          if (last_byte) begin
            // the output frame is complete even when the source overran
            cnt_d   = 16'd0;
            ident_d = ident_q + 16'd1;
            if (s_tlast) begin
              state_d = S_IDLE;
            end else begin
              len_err_d = 1'b1;
              state_d   = S_DRAIN;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
            if (s_tlast) begin
              len_err_d = 1'b1;
              state_d   = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        m_tvalid = 1'b1;
        m_tlast  = last_byte;
        if (m_tready) begin
          if (last_byte) begin
            cnt_d   = 16'd0;
            ident_d = ident_q + 16'd1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // header sections share one handshake/advance rule
    if (hdr_state) begin
      m_tvalid = 1'b1;
      if (m_tready) begin
        if (cnt_q[4:0] == hdr_end) begin
          cnt_d   = 16'd0;
          state_d = hdr_next;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_builder.sv
// Bench for frame_builder: table of length/stream cases, fixed-frame field
// checks, randomized frames against a byte-list reference model, mid-frame reset.
module tb_frame_builder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [15:0] tx_len = 16'd0;
  logic        tx_ready;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic        len_err;

  int          checks = 0;
  int          errors = 0;
  int          err_cnt = 0;
  logic [8:0]  cap_q[$];
  logic [8:0]  exp_q[$];
  int          exp_err_m;
  logic [15:0] exp_ident = 16'd0;
  logic [7:0]  pay [0:2047];

  typedef struct { int len; int nsrc; int mode; int exp_err; int exp_bytes; } vec_t;
  vec_t vecs [9];

  always #5 clk = ~clk;

  frame_builder dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_len(tx_len),
    .tx_ready(tx_ready), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .len_err(len_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] capb(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 9'h1FF;
  endfunction

  // output monitor: capture handshakes, count len_err pulses, check stall hold
  initial begin
    logic       prev_stall;
    logic [8:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = 9'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (len_err) err_cnt++;
        if (prev_stall)
          check("stall_hold", {22'h0, m_tvalid, m_tlast, m_tdata}, {22'h0, 1'b1, prev_out});
        if (m_tvalid && m_tready) cap_q.push_back({m_tlast, m_tdata});
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tlast, m_tdata};
      end
    end
  end

  // reference model: the frame as a list of {last, byte}
  task automatic build_expected(input int len, input int nsrc, input logic [15:0] id);
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [15:0] w [10];
    logic [15:0] u [4];
    logic [31:0] sum;
    int          keep;
    dmac = 48'hFFFF_FFFF_FFFF;
    smac = 48'h0200_0000_0001;
    exp_q.delete();
    exp_err_m = 1;
    if (len < 1 || len > 1472) return;
    exp_err_m = (nsrc == len) ? 0 : 1;
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, dmac[8*(5-i) +: 8]});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, smac[8*(5-i) +: 8]});
    exp_q.push_back(9'h008);
    exp_q.push_back(9'h000);
    w[0] = 16'h4500; w[1] = 16'(len + 28); w[2] = id; w[3] = 16'h4000;
    w[4] = 16'h4011; w[5] = 16'h0000; w[6] = 16'hC0A8; w[7] = 16'h0001;
    w[8] = 16'hC0A8; w[9] = 16'h0002;
`ifdef FRAME_BUILDER_IP_CSUM_EN
    sum = 32'd0;
    for (int i = 0; i < 10; i++) sum = sum + {16'h0, w[i]};
    while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    w[5] = ~sum[15:0];
`else
    sum = 32'd0;
`endif
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({1'b0, w[i][15:8]});
      exp_q.push_back({1'b0, w[i][7:0]});
    end
    u[0] = 16'd5000; u[1] = 16'd5001; u[2] = 16'(len + 8); u[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, u[i][15:8]});
      exp_q.push_back({1'b0, u[i][7:0]});
    end
    keep = (nsrc < len) ? nsrc : len;
    for (int i = 0; i < len; i++)
      exp_q.push_back({(i == len - 1), (i < keep) ? pay[i] : 8'h00});
  endtask

  // mode 0: m_tready=1, mode 1: m_tready toggles, mode 2: random valid/ready
  task automatic run_frame(input int len, input int nsrc, input int mode,
                           output int nbytes, output int nerr);
    int   idx, cyc, base;
    logic acc;
    bit   done;
    idx = 0; cyc = 0; acc = 1'b0; done = 1'b0; base = err_cnt;
    cap_q.delete();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = 16'(len); m_tready = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
    @(posedge clk); #1;
    tx_start = 1'b0;
    while (!done && cyc < 6000) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (cyc % 2 == 0);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (idx >= nsrc) s_tvalid = 1'b0;
      else if (!s_tvalid || acc) s_tvalid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata = pay[idx];
      s_tlast = (idx == nsrc - 1);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
      if (tx_ready && idx >= nsrc) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_frame_timeout len=%0d got no return to idle, expected idle within 6000 cycles", len);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nbytes = cap_q.size();
    nerr   = err_cnt - base;
  endtask

  task automatic cmp_frame(input string tag);
    int bad, first;
    bad = 0; first = -1;
    check({tag, "_size"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    check($sformatf("%s_bytes(first_diff=%0d)", tag, first), bad, 0);
  endtask

  task automatic do_frame(input int len, input int nsrc, input int mode, input string tag,
                          output int nbytes, output int nerr);
    build_expected(len, nsrc, exp_ident);
    run_frame(len, nsrc, mode, nbytes, nerr);
    cmp_frame(tag);
    check({tag, "_len_err"}, nerr, exp_err_m);
    if (len >= 1 && len <= 1472) exp_ident++;
  endtask

  initial begin
    int          nb, ne, rl, rn, rs, lasts, cyc;
    logic [8:0]  hi, lo;
    logic [31:0] sum;

    vecs[0] = '{4,    4,    0, 0, 54};
    vecs[1] = '{4,    4,    1, 0, 54};
    vecs[2] = '{6,    3,    0, 1, 56};
    vecs[3] = '{2,    5,    0, 1, 52};
    vecs[4] = '{0,    0,    0, 1, 0};
    vecs[5] = '{1473, 0,    0, 1, 0};
    vecs[6] = '{1,    1,    2, 0, 51};
    vecs[7] = '{1472, 1472, 0, 0, 1522};
    vecs[8] = '{13,   20,   2, 1, 63};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast",  m_tlast,  0);
    check("rst_m_tdata",  m_tdata,  0);
    check("rst_s_tready", s_tready, 0);
    check("rst_len_err",  len_err,  0);

    // fixed frame DE AD BE EF
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
    do_frame(4, 4, 0, "basic", nb, ne);
    check("basic_total",   nb, 54);
    check("basic_sfd",     capb(7),  9'h0D5);
    check("basic_tl_hi",   capb(24), 9'h000);
    check("basic_tl_lo",   capb(25), 9'h020);
    check("basic_udp_hi",  capb(46), 9'h000);
    check("basic_udp_lo",  capb(47), 9'h00C);
    check("basic_last_ef", capb(53), 9'h1EF);
    lasts = 0;
    foreach (cap_q[i]) if (cap_q[i][8]) lasts++;
    check("basic_last_count", lasts, 1);
`ifdef FRAME_BUILDER_IP_CSUM_EN
    sum = 32'd0;
    for (int i = 0; i < 10; i++) begin
      hi = capb(22 + 2*i); lo = capb(23 + 2*i);
      sum = sum + {16'h0, hi[7:0], lo[7:0]};
    end
    while (sum[31:16] != 16'h0) sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
    check("ip_csum_sum", sum, 32'h0000_FFFF);
`else
    check("ip_csum_hi", capb(32), 9'h000);
    check("ip_csum_lo", capb(33), 9'h000);
`endif

    // table-driven length / flow-control cases
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 2048; i++) pay[i] = 8'($urandom);
      do_frame(vecs[v].len, vecs[v].nsrc, vecs[v].mode, $sformatf("vec%0d", v), nb, ne);
      check($sformatf("vec%0d_total", v), nb, vecs[v].exp_bytes);
      check($sformatf("vec%0d_err", v), ne, vecs[v].exp_err);
    end

    // randomized frames against the model
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
      rl = $urandom_range(1, 40);
      rs = $urandom_range(0, 2);
      rn = (rs == 0) ? rl : (rs == 1) ? $urandom_range(1, rl) : rl + $urandom_range(1, 5);
      do_frame(rl, rn, $urandom_range(0, 2), $sformatf("rnd%0d", r), nb, ne);
    end

    // reset in the middle of a frame
    for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
    cap_q.delete();
    @(posedge clk); #1;
    tx_start = 1'b1; tx_len = 16'd8; m_tready = 1'b1; s_tvalid = 1'b0;
    @(posedge clk); #1;
    tx_start = 1'b0;
    cyc = 0;
    while (cap_q.size() < 30 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 100) begin
      checks++; errors++;
      $display("FAIL midrst_wait got %0d bytes, expected 30 within 100 cycles", cap_q.size());
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_tx_ready", tx_ready, 1);
    rst_n = 1'b1;
    lasts = 0;
    foreach (cap_q[i]) if (cap_q[i][8]) lasts++;
    check("midrst_no_tlast", lasts, 0);
    exp_ident = 16'd0;

    // consecutive frames carry ident 0, 1, 2 after reset
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
      do_frame(3, 3, 0, $sformatf("seq%0d", f), nb, ne);
      hi = capb(26); lo = capb(27);
      check($sformatf("seq%0d_ident", f), {16'h0, hi[7:0], lo[7:0]}, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
